// File: rtl/input_debouncer_pkg.sv
// Shared types and defaults for the push-button / slide-switch debouncer.
package input_debouncer_pkg;

  // Per-bit filter state: settled, or watching a candidate new level.
  typedef enum logic {DB_STABLE, DB_PENDING} db_state_t;

  // 10 ms at 50 MHz.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

  // KEY[3:0] are active-low on the board; flipping them here makes every
  // bit active-high downstream.
  localparam logic [7:0] KEY_INVERT_MASK = 8'h0F;

endpackage

// File: rtl/input_debouncer_debounce_bit.sv
// One input bit: two-flop synchroniser, stability counter and two-state
// acceptance FSM with registered level and one-cycle edge pulses.
module debounce_bit
  import input_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_x,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int                   CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 r_s1;
  logic                 r_s2;
  db_state_t            r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_level;
  logic                 r_rise;
  logic                 r_fall;

  // Two-flop synchroniser for the asynchronous pin; nothing sits between stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_x;
      r_s2 <= r_s1;
    end
  end

  // Accept a new level only after it differs from the current one on
  // DEBOUNCE_CYCLES+1 consecutive edges; any return to the old level restarts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= DB_STABLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        DB_STABLE: begin
          if (r_s2 != r_level) begin
            r_state <= DB_PENDING;
            r_cnt   <= '0;
          end
        end
        DB_PENDING: begin
          if (r_s2 == r_level) begin
            // Glitch shorter than the window: drop it silently.
            r_state <= DB_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            // Exit happens at the last count, so the counter never wraps.
            r_level <= r_s2;
            r_rise  <= r_s2;
            r_fall  <= ~r_s2;
            r_state <= DB_STABLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          r_state <= DB_STABLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/input_debouncer.sv
// Per-bit synchroniser and debounce filter feeding the edge-capture PIO.
// Each bit is filtered independently; rise/fall pulses and a combined
// any_change strobe are provided for fabric-side consumers.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int               WIDTH           = 8,
  parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [WIDTH-1:0] INVERT_MASK     = WIDTH'(KEY_INVERT_MASK)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] debounced_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);

  logic [WIDTH-1:0] w_x;

  // Polarity correction happens before synchronisation so the filter only
  // ever sees active-high senses.
  assign w_x = raw_in ^ INVERT_MASK;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .i_x    (w_x[g]),
      .o_level(debounced_out[g]),
      .o_rise (rise_pulse[g]),
      .o_fall (fall_pulse[g])
    );
  end

  // Several bits accepting together still give a single-cycle strobe.
  assign any_change = |(rise_pulse | fall_pulse);

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Per-bit synchroniser and debounce filter for the board push-buttons and slide switches.
- Sits directly upstream of the 8-bit edge-capture PIO. Its debounced_out drives the PIO in_port, so the PIO edge capture and IRQ see exactly one clean edge per physical press.
- Each bit is filtered independently: a new level is accepted only after it has been stable for a programmable number of clocks.
- Also produces one-cycle rise/fall pulses for fabric-side consumers.

Parameters:
- WIDTH, 8: number of input bits.
- DEBOUNCE_CYCLES, 500000: stable-sample count required to accept a new level (10 ms at 50 MHz). Legal range 2 to 2^24.
- INVERT_MASK, 8'h0F: per-bit XOR applied to raw_in before synchronisation. Set bits convert the active-low KEY[3:0] to active-high.
- CNT_WIDTH, $clog2(DEBOUNCE_CYCLES): localparam, counter width.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- raw_in  input  WIDTH  asynchronous pin inputs
- debounced_out  output  WIDTH  filtered level, to PIO in_port
- rise_pulse  output  WIDTH  one-cycle pulse on accepted 0->1
- fall_pulse  output  WIDTH  one-cycle pulse on accepted 1->0
- any_change  output  1  OR of rise_pulse and fall_pulse

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, named reset_n. All flops use posedge clk / negedge reset_n.
- Reset values:
  - sync stages s1/s2 = 0, per-bit state = STABLE, counters = 0.
  - debounced_out = 0, rise_pulse = 0, fall_pulse = 0, any_change = 0.
  - Reset asserted mid-count discards the pending transition. After release, bits whose inverted input is 1 go through a full debounce before asserting.
- Input conditioning: x = raw_in ^ INVERT_MASK (combinational), then a two-flop synchroniser: s1 <= x, s2 <= s1. No logic between s1 and s2.
- Per-bit FSM, two states:
  - STABLE: if s2 != debounced_out -> PENDING, cnt <= 0. Otherwise hold.
  - PENDING, s2 == debounced_out: -> STABLE, cnt <= 0. The glitch is rejected and no pulse is issued.
  - PENDING, s2 != debounced_out and cnt == DEBOUNCE_CYCLES-1: debounced_out <= s2, -> STABLE, cnt <= 0, and the matching pulse is set for exactly one cycle.
  - PENDING otherwise: cnt <= cnt + 1.
- Acceptance rule: s2 must differ from debounced_out on DEBOUNCE_CYCLES+1 consecutive sampled edges.
- Latency: a raw change held steady changes debounced_out DEBOUNCE_CYCLES+3 rising edges after the first edge that samples it into s1. A disturbance lasting DEBOUNCE_CYCLES cycles or fewer never propagates.
- Pulses:
  - rise_pulse/fall_pulse are registered and coincide with the debounced_out update cycle.
  - They are cleared the next cycle unless a new acceptance occurs.
  - Rise and fall of the same bit are never asserted together.
- any_change is the combinational OR-reduce of rise_pulse | fall_pulse.
- Counter: saturates logically via the compare. It never wraps, because the exit occurs at DEBOUNCE_CYCLES-1.
- Simultaneous events: bits are fully independent. Several bits may accept in the same cycle; any_change is still a single-cycle pulse.
- Continuous bounce: counter restarts on every return to the old level, and debounced_out holds the old value indefinitely.

Decomposition:
- Shared package input_debouncer_pkg holds:
  - typedef enum logic {DB_STABLE, DB_PENDING} db_state_t
  - DEFAULT_DEBOUNCE_CYCLES = 500000
  - KEY_INVERT_MASK = 8'h0F
- Sub-module debounce_bit: one synchroniser, counter and FSM, with outputs level/rise/fall. The top generates WIDTH instances and forms any_change.

Test Plan (DEBOUNCE_CYCLES=4, INVERT_MASK=0 unless noted):
1. Reset with raw_in=8'hFF held, then release -> outputs 0 during reset; debounced_out=8'hFF exactly 7 edges after first post-reset edge; rise_pulse=8'hFF for one cycle; any_change=1 for one cycle.
2. bit0 high for 4 cycles then low -> debounced_out[0] stays 0; no rise_pulse.
3. bit0 high for 5 cycles -> debounced_out[0]=1 at edge 7; rise_pulse[0] single cycle. Drop bit0 for 5 cycles -> fall_pulse[0] single cycle; debounced_out[0]=0.
4. bit3 toggles every 2 cycles for 100 cycles then settles high -> exactly one rise_pulse[3], 7 edges after the final settle; no fall_pulse.
5. INVERT_MASK=8'h0F, raw_in=8'hF0 constant -> debounced_out=8'hFF after settling. Pulse raw_in[1] low for 6 cycles -> no change, since the inverted sense goes 0 only while raw is high.
6. Assert reset_n=0 while bit2 is at cnt=2 in PENDING -> immediate outputs 0; after release, the bit requires the full 7-edge latency again.
